// File: rtl/led_pkg.sv
// Shared constants, FSM state type and address helper for the LED matrix scan controller.
package led_pkg;

   localparam int LED_ROWS     = 3;
   localparam int LED_COLS     = 11;
   localparam int LED_PWM_BITS = 8;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

   function automatic logic [5:0] led_addr(input int row, input int col);
      return 6'(row * LED_COLS + col);
   endfunction

endpackage

// File: rtl/led_bright_ram.sv
// Per-LED brightness storage: one synchronous write port, one full-row combinational read port.
module led_bright_ram
   import led_pkg::*;
#(
   parameter  int ROWS     = LED_ROWS,
   parameter  int COLS     = LED_COLS,
   parameter  int PWM_BITS = LED_PWM_BITS,
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [5:0]               wr_addr,
   input  logic [PWM_BITS-1:0]      wr_data,
   input  logic [ROW_W-1:0]         rd_row,
   output logic [COLS*PWM_BITS-1:0] rd_data
);

   logic [PWM_BITS-1:0] mem [ROWS*COLS];

   // Full address decode: indices past the last LED match no entry and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROWS*COLS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < ROWS*COLS; i++) begin
            if (wr_addr == 6'(i)) mem[i] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (rd_row == ROW_W'(r)) begin
            for (int c = 0; c < COLS; c++) rd_data[c*PWM_BITS +: PWM_BITS] = mem[r*COLS + c];
         end
      end
   end

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-multiplexed LED matrix scanner with per-column PWM and inter-row blanking.
//   state | meaning
//   BLANK | all outputs dark, phase_ctr counts blank cycles; row latch loaded on exit
//   ON    | one anode row driven, cathodes PWM-compared against the row latch
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int ROWS      = LED_ROWS,
   parameter int COLS      = LED_COLS,
   parameter int PWM_BITS  = LED_PWM_BITS,
   parameter int BLANK_CYC = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [5:0]          wr_addr,
   input  logic [PWM_BITS-1:0] wr_data,
   output logic [ROWS-1:0]     leda,
   output logic [COLS-1:0]     ledc,
   output logic                frame_start
);

   localparam int                  ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PWM_BITS-1:0] BLANK_LAST = PWM_BITS'(BLANK_CYC - 1);
   localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [ROWS-1:0]     ROW_ONE    = ROWS'(1);

   scan_state_t              state;
   logic [ROW_W-1:0]         row;
   logic [PWM_BITS-1:0]      phase_ctr;
   logic [PWM_BITS-1:0]      row_latch [COLS];
   logic [COLS*PWM_BITS-1:0] row_data;

   led_bright_ram #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .PWM_BITS (PWM_BITS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_row  (row),
      .rd_data (row_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BLANK;
         row         <= '0;
         phase_ctr   <= '0;
         for (int c = 0; c < COLS; c++) row_latch[c] <= '0;
         leda        <= '0;
         ledc        <= '0;
         frame_start <= 1'b0;
      end else begin
         leda        <= '0;
         ledc        <= '0;
         frame_start <= 1'b0;
         case (state)
            BLANK: begin
               if (phase_ctr == BLANK_LAST) begin
                  state     <= ON;
                  phase_ctr <= '0;
                  // A write landing on this same edge is not seen until the row's next scan.
                  for (int c = 0; c < COLS; c++) row_latch[c] <= row_data[c*PWM_BITS +: PWM_BITS];
               end else begin
                  phase_ctr <= phase_ctr + 1'b1;
               end
            end
            ON: begin
               leda        <= ROW_ONE << row;
               frame_start <= (row == '0) && (phase_ctr == '0);
               for (int c = 0; c < COLS; c++) ledc[c] <= (phase_ctr < row_latch[c]);
               if (phase_ctr == '1) begin
                  state     <= BLANK;
                  phase_ctr <= '0;
                  row       <= (row == ROW_LAST) ? '0 : row + 1'b1;
               end else begin
                  phase_ctr <= phase_ctr + 1'b1;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: expected per-scan cathode counts queued, monitor measures each ON phase.
module tb_led_scan_ctrl;
   import led_pkg::*;

   localparam int ROWS = 3, COLS = 11, PWMB = 8, BLANK_CYC = 4;
   localparam int ON_LEN = 256, FRAME_LEN = 780, N_SCANS = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic [5:0]       wr_addr = '0;
   logic [PWMB-1:0]  wr_data = '0;
   logic [ROWS-1:0]  leda;
   logic [COLS-1:0]  ledc;
   logic             frame_start;

   led_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWMB), .BLANK_CYC(BLANK_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .leda        (leda),
      .ledc        (ledc),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]        leda;
      logic [10:0][8:0]  cnt;
   } scan_t;

   scan_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    scans_done = 0;
   bit    armed = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout, expected DUT event", name);
   endtask

   function automatic scan_t mk(input logic [2:0] a, input int c0, input int c1, input int c2,
                                input int c3, input int c10);
      scan_t s;
      s = '0;
      s.leda    = a;
      s.cnt[0]  = 9'(c0);
      s.cnt[1]  = 9'(c1);
      s.cnt[2]  = 9'(c2);
      s.cnt[3]  = 9'(c3);
      s.cnt[10] = 9'(c10);
      return s;
   endfunction

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_scan_start(input logic [2:0] val, input string name);
      logic [2:0] prev;
      bit         hit;
      prev = leda;
      hit  = 1'b0;
      for (int i = 0; i < 1500 && !hit; i++) begin
         @(posedge clk); #1;
         if (leda == val && prev != val) hit = 1'b1;
         prev = leda;
      end
      if (!hit) timeout_fail(name);
   endtask

   // ---------------- monitor ----------------
   bit         in_on, seen_scan, prefix_bad, chg_bad, fs_bad, dark_bad, have_fs;
   int         on_len, blank_len, cyc, last_fs;
   int         cnt [COLS];
   bit         low_seen [COLS];
   logic [2:0] cur_leda;
   scan_t      exp_s;

   initial begin : monitor
      cyc = 0; in_on = 0; seen_scan = 0; have_fs = 0; blank_len = 0; dark_bad = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!armed || rst) begin
            in_on = 0; seen_scan = 0; blank_len = 0; dark_bad = 0; have_fs = 0;
         end else if (leda != 0) begin
            if (!in_on) begin
               in_on = 1; on_len = 0; cur_leda = leda;
               prefix_bad = 0; chg_bad = 0; fs_bad = 0;
               for (int c = 0; c < COLS; c++) begin cnt[c] = 0; low_seen[c] = 0; end
               if (seen_scan) chk("blank_len", blank_len, BLANK_CYC);
               chk("blank_dark", int'(dark_bad), 0);
               chk("frame_start_at_row_start", int'(frame_start), int'(leda == 3'b001));
               if (frame_start) begin
                  if (have_fs) chk("frame_period", cyc - last_fs, FRAME_LEN);
                  have_fs = 1; last_fs = cyc;
               end
            end else if (frame_start) begin
               fs_bad = 1;
            end
            if (leda != cur_leda) chg_bad = 1;
            on_len++;
            for (int c = 0; c < COLS; c++) begin
               if (ledc[c]) begin
                  cnt[c]++;
                  if (low_seen[c]) prefix_bad = 1;
               end else begin
                  low_seen[c] = 1;
               end
            end
         end else begin
            if (in_on) begin
               in_on = 0; seen_scan = 1; blank_len = 0; dark_bad = 0;
               chk("on_len", on_len, ON_LEN);
               chk("pwm_prefix", int'(prefix_bad), 0);
               chk("leda_stable_onehot", int'(chg_bad), 0);
               chk("frame_start_single", int'(fs_bad), 0);
               if (sb.size() == 0) begin
                  timeout_fail("scan_unexpected");
               end else begin
                  exp_s = sb.pop_front();
                  chk($sformatf("scan%0d_leda", scans_done), int'(cur_leda), int'(exp_s.leda));
                  for (int c = 0; c < COLS; c++)
                     chk($sformatf("scan%0d_col%0d_count", scans_done, c), cnt[c], int'(exp_s.cnt[c]));
               end
               scans_done++;
            end
            if (ledc != 0 || frame_start) dark_bad = 1;
            blank_len++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int  n;
      bit  hit;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(posedge clk); #1;
         if (leda != 0) hit = 1;
      end
      if (!hit) timeout_fail("pre_reset_on");
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("reset_leda", int'(leda), 0);
      chk("reset_ledc", int'(ledc), 0);
      chk("reset_frame_start", int'(frame_start), 0);
      repeat (4) @(posedge clk);

      sb.push_back(mk(3'b001,   0, 0,   0,   0,  0));
      sb.push_back(mk(3'b010,   0, 0,   0,   0,  0));
      sb.push_back(mk(3'b100,   0, 0,   0,   0,  0));
      sb.push_back(mk(3'b001,   0, 1, 128, 255,  0));
      sb.push_back(mk(3'b010, 255, 0,   0,   0,  0));
      sb.push_back(mk(3'b100,   0, 0,   0,   0, 64));
      sb.push_back(mk(3'b001,  50, 1, 128, 255,  0));
      sb.push_back(mk(3'b010, 255, 0,   0,   0,  0));
      sb.push_back(mk(3'b100,   0, 0,   0,   0, 64));
      sb.push_back(mk(3'b001, 200, 1, 128, 255,  0));
      sb.push_back(mk(3'b010, 255, 0,   0,   0,  0));
      sb.push_back(mk(3'b100,   0, 0,   0,   0, 64));
      sb.push_back(mk(3'b001, 200, 1, 128, 255,  0));
      sb.push_back(mk(3'b010,  20, 0,   0,   0,  0));
      sb.push_back(mk(3'b100,   0, 0,   0,   0, 64));

      #1;
      armed = 1'b1;
      rst   = 1'b0;

      n = 0; hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(posedge clk); #1;
         n++;
         if (leda != 0) hit = 1;
      end
      if (!hit) timeout_fail("first_on");
      chk("first_on_latency", n, BLANK_CYC + 1);
      chk("first_on_leda", int'(leda), 1);
      chk("first_on_frame_start", int'(frame_start), 1);

      // frame 0, row 2 ON: load duty, mapping and out-of-range patterns
      wait_scan_start(3'b100, "wait_f0_row2");
      wr(led_addr(0, 0), 8'd0);
      wr(led_addr(0, 1), 8'd1);
      wr(led_addr(0, 2), 8'd128);
      wr(led_addr(0, 3), 8'd255);
      wr(led_addr(1, 0), 8'd255);
      wr(led_addr(2, 10), 8'd64);
      wr(6'd33, 8'd77);
      wr(6'd63, 8'd99);

      wait_scan_start(3'b010, "wait_f1_row1");
      wr(led_addr(0, 0), 8'd50);

      // frame 2, row 0 ON at phase ~100: must not disturb the current scan
      wait_scan_start(3'b001, "wait_f2_row0");
      repeat (99) @(posedge clk);
      #1 wr(led_addr(0, 0), 8'd200);

      // frame 3: write addr 11 on the edge that latches row 1
      wait_scan_start(3'b001, "wait_f3_row0");
      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(posedge clk); #1;
         if (leda == 0) hit = 1;
      end
      if (!hit) timeout_fail("wait_f3_blank");
      repeat (2) @(posedge clk);
      #1 wr(led_addr(1, 0), 8'd20);

      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(posedge clk); #1;
         if (scans_done >= N_SCANS) hit = 1;
      end
      if (!hit) timeout_fail("scans_complete");
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
